// File: rtl/uc_if.sv
// uc_if: decode inputs and control-word outputs exchanged between the
// microc control unit (slave) and whatever drives its inputs (master).
interface uc_if;
    logic [5:0]  Opcode;
    logic        z;
    logic        run;
    logic        step;
    logic        s_inc;
    logic        s_inm;
    logic        we3;
    logic        wez;
    logic [2:0]  Op;
    logic        pc_we;
    logic [1:0]  state;
    logic        illegal;
    logic [15:0] perf_icnt;
    logic [15:0] perf_bcnt;

    modport master (
        output Opcode, z, run, step,
        input  s_inc, s_inm, we3, wez, Op, pc_we, state, illegal,
               perf_icnt, perf_bcnt
    );

    modport slave (
        input  Opcode, z, run, step,
        output s_inc, s_inm, we3, wez, Op, pc_we, state, illegal,
               perf_icnt, perf_bcnt
    );
endinterface

// File: rtl/uc_fsm.sv
// uc_fsm: microc control unit. Zero-latency opcode decode into the datapath
// control word, gated by a BOOT/RUN/PAUSE/HALT debug state machine.
// Optional feature macro: UC_PERF_CNT_EN builds saturating 16-bit counters
// for retired instructions and taken jumps; otherwise both read zero.
module uc_fsm (
    input  logic clk,
    input  logic reset,
    uc_if.slave  bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_HALT  = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic       legal_c;
    logic       exec_c;
    logic       retire_c;
    logic       taken_c;
    logic       s_inc_c;
    logic       s_inm_c;
    logic       we3_c;
    logic       wez_c;
    logic [2:0] op_c;
    logic       pc_we_c;

    // Opcode legality and taken-jump detection
    always_comb begin
        legal_c = 1'b0;
        taken_c = 1'b0;
        casez (bus.Opcode)
            6'b1?????: legal_c = 1'b1;
            6'b000000: legal_c = 1'b1;
            6'b0001??: legal_c = 1'b1;
            6'b010000: begin legal_c = 1'b1; taken_c = 1'b1;   end
            6'b010001: begin legal_c = 1'b1; taken_c = bus.z;  end
            6'b010010: begin legal_c = 1'b1; taken_c = ~bus.z; end
            default:   legal_c = 1'b0;
        endcase
    end

    assign exec_c   = ((state_q == ST_RUN) && bus.run) ||
                      ((state_q == ST_PAUSE) && bus.step);
    assign retire_c = exec_c && legal_c;

    // Control word: idle unless a legal instruction executes this cycle
    always_comb begin
        s_inc_c = 1'b1;
        s_inm_c = 1'b0;
        we3_c   = 1'b0;
        wez_c   = 1'b0;
        op_c    = 3'b000;
        pc_we_c = 1'b0;
        if (retire_c) begin
            pc_we_c = 1'b1;
            casez (bus.Opcode)
                6'b1?????: begin
                    we3_c = 1'b1;
                    wez_c = 1'b1;
                    op_c  = bus.Opcode[4:2];
                end
                6'b0001??: begin
                    we3_c   = 1'b1;
                    s_inm_c = 1'b1;
                end
                6'b010000: s_inc_c = 1'b0;
                6'b010001: s_inc_c = ~bus.z;
                6'b010010: s_inc_c = bus.z;
                default:   s_inc_c = 1'b1;
            endcase
        end
    end

    // Next-state: illegal opcode seen in an executing cycle halts for good
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:  state_d = bus.run ? ST_RUN : ST_PAUSE;
            ST_RUN: begin
                if (!bus.run)     state_d = ST_PAUSE;
                else if (!legal_c) state_d = ST_HALT;
            end
            ST_PAUSE: begin
                if (bus.step && !legal_c) state_d = ST_HALT;
                else if (bus.run)         state_d = ST_RUN;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_BOOT;
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_BOOT;
        else        state_q <= state_d;
    end

    assign bus.s_inc   = s_inc_c;
    assign bus.s_inm   = s_inm_c;
    assign bus.we3     = we3_c;
    assign bus.wez     = wez_c;
    assign bus.Op      = op_c;
    assign bus.pc_we   = pc_we_c;
    assign bus.state   = state_q;
    assign bus.illegal = (state_q == ST_HALT);

`ifdef UC_PERF_CNT_EN
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;

    // Saturating retire / taken-jump counters
    always_comb begin
        icnt_d = icnt_q;
        bcnt_d = bcnt_q;
        if (retire_c && (icnt_q != {CNT_W{1'b1}}))
            icnt_d = icnt_q + CNT_W'(1);
        if (retire_c && taken_c && (bcnt_q != {CNT_W{1'b1}}))
            bcnt_d = bcnt_q + CNT_W'(1);
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            icnt_q <= '0;
            bcnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign bus.perf_icnt = icnt_q;
    assign bus.perf_bcnt = bcnt_q;
`else
    assign bus.perf_icnt = CNT_W'(0);
    assign bus.perf_bcnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_uc_fsm.sv
// tb_uc_fsm: directed, self-checking bench for uc_fsm.
// Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
module tb_uc_fsm;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    uc_if bus ();

    uc_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] OP_ALU1 = 6'b100100;
    localparam logic [5:0] OP_ALU7 = 6'b111100;
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LI   = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_BAD  = 6'b011111;

    // Expected counter value: real count with counters built, else zero
    function automatic logic [15:0] ec(input int n);
`ifdef UC_PERF_CNT_EN
        return 16'(n);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".pc_we"}, 16'(bus.pc_we), 16'h0);
        chk({tag, ".we3"},   16'(bus.we3),   16'h0);
        chk({tag, ".wez"},   16'(bus.wez),   16'h0);
        chk({tag, ".s_inm"}, 16'(bus.s_inm), 16'h0);
        chk({tag, ".s_inc"}, 16'(bus.s_inc), 16'h1);
        chk({tag, ".Op"},    16'(bus.Op),    16'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset      = 1'b0;
        bus.run    = 1'b1;
        bus.step   = 1'b0;
        bus.z      = 1'b0;
        bus.Opcode = OP_ALU1;

        // Reset low for two edges
        tick();
        tick();
        settle();
        chk("rst.state", 16'(bus.state), 16'h0);
        chk("rst.illegal", 16'(bus.illegal), 16'h0);
        chk_idle("rst");
        chk("rst.icnt", bus.perf_icnt, 16'h0);
        chk("rst.bcnt", bus.perf_bcnt, 16'h0);

        // Release: BOOT still holds for one cycle, nothing executes
        reset = 1'b1;
        settle();
        chk("boot.state", 16'(bus.state), 16'h0);
        chk_idle("boot");
        tick();
        settle();
        chk("run.state", 16'(bus.state), 16'h1);
        chk("alu.we3", 16'(bus.we3), 16'h1);
        chk("alu.wez", 16'(bus.wez), 16'h1);
        chk("alu.Op", 16'(bus.Op), 16'h1);
        chk("alu.pc_we", 16'(bus.pc_we), 16'h1);
        chk("alu.s_inc", 16'(bus.s_inc), 16'h1);
        chk("alu.s_inm", 16'(bus.s_inm), 16'h0);
        tick();                                       // icnt 1

        bus.Opcode = OP_ALU7;
        settle();
        chk("alu7.Op", 16'(bus.Op), 16'h7);
        tick();                                       // icnt 2

        bus.Opcode = OP_LI;
        settle();
        chk("li.s_inm", 16'(bus.s_inm), 16'h1);
        chk("li.we3", 16'(bus.we3), 16'h1);
        chk("li.wez", 16'(bus.wez), 16'h0);
        chk("li.s_inc", 16'(bus.s_inc), 16'h1);
        chk("li.Op", 16'(bus.Op), 16'h0);
        tick();                                       // icnt 3

        bus.Opcode = OP_J;
        settle();
        chk("j.s_inc", 16'(bus.s_inc), 16'h0);
        chk("j.pc_we", 16'(bus.pc_we), 16'h1);
        chk("j.we3", 16'(bus.we3), 16'h0);
        tick();                                       // icnt 4, bcnt 1
        chk("j.bcnt", bus.perf_bcnt, ec(1));
        chk("j.icnt", bus.perf_icnt, ec(4));

        bus.Opcode = OP_JZ; bus.z = 1'b1;
        settle();
        chk("jz_z1.s_inc", 16'(bus.s_inc), 16'h0);
        tick();                                       // icnt 5, bcnt 2
        bus.z = 1'b0;
        settle();
        chk("jz_z0.s_inc", 16'(bus.s_inc), 16'h1);
        chk("jz_z0.pc_we", 16'(bus.pc_we), 16'h1);
        tick();                                       // icnt 6
        bus.Opcode = OP_JNZ; bus.z = 1'b1;
        settle();
        chk("jnz_z1.s_inc", 16'(bus.s_inc), 16'h1);
        tick();                                       // icnt 7
        bus.z = 1'b0;
        settle();
        chk("jnz_z0.s_inc", 16'(bus.s_inc), 16'h0);
        tick();                                       // icnt 8, bcnt 3
        chk("jumps.bcnt", bus.perf_bcnt, ec(3));

        bus.Opcode = OP_NOP;
        settle();
        chk("nop.pc_we", 16'(bus.pc_we), 16'h1);
        chk("nop.we3", 16'(bus.we3), 16'h0);
        chk("nop.s_inc", 16'(bus.s_inc), 16'h1);
        tick();                                       // icnt 9
        chk("nop.icnt", bus.perf_icnt, ec(9));

        // Drop run: no execution in the transition cycle
        bus.Opcode = OP_ALU1;
        bus.run = 1'b0;
        settle();
        chk_idle("run_drop");
        tick();
        chk("pause.state", 16'(bus.state), 16'h2);
        chk("pause.pc_we", 16'(bus.pc_we), 16'h0);

        // Three single-cycle step pulses
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1;
            settle();
            chk("step.pc_we", 16'(bus.pc_we), 16'h1);
            chk("step.we3", 16'(bus.we3), 16'h1);
            tick();
            bus.step = 1'b0;
            settle();
            chk("step_gap.pc_we", 16'(bus.pc_we), 16'h0);
            chk("step_gap.state", 16'(bus.state), 16'h2);
            tick();
        end
        chk("steps.icnt", bus.perf_icnt, ec(12));

        // Illegal step in PAUSE halts
        bus.Opcode = OP_BAD;
        settle();
        chk_idle("pause_bad_nostep");
        tick();
        chk("pause_bad_nostep.state", 16'(bus.state), 16'h2);
        bus.step = 1'b1;
        settle();
        chk_idle("pause_bad_step");
        tick();
        bus.step = 1'b0;
        chk("pause_bad.state", 16'(bus.state), 16'h3);
        chk("pause_bad.illegal", 16'(bus.illegal), 16'h1);

        // Reset out of HALT, come up in PAUSE, then resume with run+step
        reset = 1'b0;
        bus.Opcode = OP_ALU1;
        tick();
        chk("rst2.state", 16'(bus.state), 16'h0);
        chk("rst2.illegal", 16'(bus.illegal), 16'h0);
        chk("rst2.icnt", bus.perf_icnt, 16'h0);
        reset = 1'b1;
        bus.run = 1'b0;
        tick();
        chk("boot2pause.state", 16'(bus.state), 16'h2);
        bus.run = 1'b1;
        bus.step = 1'b1;
        settle();
        chk("resume_step.pc_we", 16'(bus.pc_we), 16'h1);
        tick();
        bus.step = 1'b0;
        chk("resume.state", 16'(bus.state), 16'h1);
        chk("resume.icnt", bus.perf_icnt, ec(1));

        // Illegal opcode in RUN: no writes now, HALT next cycle, sticky
        bus.Opcode = OP_BAD;
        settle();
        chk_idle("run_bad");
        chk("run_bad.state", 16'(bus.state), 16'h1);
        chk("run_bad.illegal", 16'(bus.illegal), 16'h0);
        tick();
        chk("halt.state", 16'(bus.state), 16'h3);
        chk("halt.illegal", 16'(bus.illegal), 16'h1);
        bus.Opcode = OP_ALU1;
        bus.run = 1'b0;
        bus.step = 1'b1;
        settle();
        chk_idle("halt_step");
        tick();
        bus.run = 1'b1;
        bus.step = 1'b0;
        tick();
        chk("halt_sticky.state", 16'(bus.state), 16'h3);
        chk("halt_sticky.illegal", 16'(bus.illegal), 16'h1);
        chk("halt_sticky.icnt", bus.perf_icnt, ec(1));

        // Reset asserted mid-run wins; successor cycle is idle BOOT
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rerun.state", 16'(bus.state), 16'h1);
        reset = 1'b0;
        settle();
        tick();
        chk("midrst.state", 16'(bus.state), 16'h0);
        chk_idle("midrst");
        reset = 1'b1;
        tick();

        // Long run for counter saturation
        for (int i = 0; i < 65540; i++) tick();
        chk("sat.icnt", bus.perf_icnt, ec(16'hFFFF));
        chk("sat.bcnt", bus.perf_bcnt, 16'h0);
        chk("sat.state", 16'(bus.state), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
